// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO for the I2S output path.
// The head entry is presented combinationally on fifo_out_data as soon as the
// FIFO is non-empty. Occupancy is tracked in a level counter, which is the sole
// source for the full, empty and watermark status.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous clear of contents (error flags kept)
//   clr_err         synchronous clear of overflow/underflow
//   fifo_inp_*      write side: data, rts (writer has data), rtr (not full)
//   fifo_out_*      read side: data (head or 0), rts (not empty), rtr (reader takes)
//   fifo_level      occupancy 0..DEPTH
//   almost_full     level >= AF_THRESH
//   almost_empty    level <= AE_THRESH
//   overflow        sticky: push attempted while full
//   underflow       sticky: pop attempted while empty
module fifo_fwft #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] fifo_inp_data,
    input  logic                  fifo_inp_rts,
    output logic                  fifo_inp_rtr,
    output logic [DATA_WIDTH-1:0] fifo_out_data,
    output logic                  fifo_out_rts,
    input  logic                  fifo_out_rtr,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LVL_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  push;
    logic                  pop;

    // Status decoded from the registered level only
    assign fifo_inp_rtr = (level != LVL_W'(DEPTH));
    assign fifo_out_rts = (level != '0);
    assign almost_full  = (level >= LVL_W'(AF_THRESH));
    assign almost_empty = (level <= LVL_W'(AE_THRESH));
    assign fifo_level   = level;

    assign push = fifo_inp_rts & fifo_inp_rtr;
    assign pop  = fifo_out_rts & fifo_out_rtr;

    // Head of queue falls through; forced to zero when empty so stale memory never leaks
    assign fifo_out_data = fifo_out_rts ? mem[rd_ptr] : '0;

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= fifo_inp_data;
        end
    end

    // Pointers and level; flush discards any transfer in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (fifo_inp_rts & ~fifo_inp_rtr) | (overflow  & ~clr_err);
            underflow <= (fifo_out_rtr & ~fifo_out_rts) | (underflow & ~clr_err);
        end
    end

endmodule
